// File: rtl/dsp_post_stage_pkg.sv
// dsp_post_stage_pkg
//   Shared constants for the DSP post-adder stage: data widths, opmode field
//   positions and the X/Z operand select encodings.
package dsp_post_stage_pkg;

  localparam int DAT_W       = 48;
  localparam int M_W         = 36;
  localparam int OPM_W       = 8;

  localparam int OPM_X_LSB   = 0;
  localparam int OPM_Z_LSB   = 2;
  localparam int OPM_SUB_BIT = 7;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_e;

endpackage

// File: rtl/dsp_pipe_reg_arn.sv
// dsp_pipe_reg_arn
//   Optional pipeline register with clock enable and asynchronous active-low
//   reset. With USE_REG=0 the register is removed and q follows d.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears q when registered)
//   ce     clock enable
//   d      data in  [W-1:0]
//   q      data out [W-1:0]
module dsp_pipe_reg_arn #(
  parameter int W       = 1,
  parameter bit USE_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (USE_REG) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          q <= '0;
        else if (ce)
          q <= d;
      end
    end else begin : g_bypass
      // clk/rst_n/ce have no function in bypass mode
      logic unused_ctl;
      assign unused_ctl = &{1'b0, clk, rst_n, ce};
      assign q = d;
    end
  endgenerate

endmodule

// File: rtl/dsp_post_stage.sv
// dsp_post_stage
//   Post-multiplier stage of a DSP slice: optional M register, X/Z operand
//   muxes, 48-bit add/subtract with carry-in, optional P and carry-out
//   registers. Each optional register can be bypassed by parameter.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   cem, cep, ceopmode, cecarryin     clock enables (M, P+carryout, opmode, carry-in)
//   m        [35:0]  multiplier product
//   dab      [47:0]  {d[11:0], a[17:0], b[17:0]}
//   c        [47:0]  C operand
//   pcin     [47:0]  cascade input
//   carryin          post-adder carry-in
//   opmode   [7:0]   [1:0] X sel, [3:2] Z sel, [7] subtract
//   p, pcout [47:0]  result (pcout == p)
//   m_out    [35:0]  M stage output
//   carryout, carryoutf  carry from bit 47 (identical)
module dsp_post_stage
  import dsp_post_stage_pkg::*;
#(
  parameter int MREG        = 1,
  parameter int PREG        = 1,
  parameter int OPMODEREG   = 1,
  parameter int CARRYINREG  = 1,
  parameter int CARRYOUTREG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cem,
  input  logic             cep,
  input  logic             ceopmode,
  input  logic             cecarryin,
  input  logic [M_W-1:0]   m,
  input  logic [DAT_W-1:0] dab,
  input  logic [DAT_W-1:0] c,
  input  logic [DAT_W-1:0] pcin,
  input  logic             carryin,
  input  logic [OPM_W-1:0] opmode,
  output logic [DAT_W-1:0] p,
  output logic [DAT_W-1:0] pcout,
  output logic [M_W-1:0]   m_out,
  output logic             carryout,
  output logic             carryoutf
);

  logic [M_W-1:0]   m_q;
  logic [OPM_W-1:0] opm_q;
  logic             cin_q;
  logic [DAT_W-1:0] p_q;
  logic [DAT_W-1:0] p_fb;
  logic             cout_q;
  logic [DAT_W-1:0] x_op;
  logic [DAT_W-1:0] z_op;
  logic [DAT_W:0]   res;
  x_sel_e           x_sel;
  z_sel_e           z_sel;
  logic             sub;

  dsp_pipe_reg_arn #(.W(M_W), .USE_REG(MREG != 0)) u_mreg (
    .clk(clk), .rst_n(rst_n), .ce(cem), .d(m), .q(m_q)
  );

  dsp_pipe_reg_arn #(.W(OPM_W), .USE_REG(OPMODEREG != 0)) u_opmreg (
    .clk(clk), .rst_n(rst_n), .ce(ceopmode), .d(opmode), .q(opm_q)
  );

  dsp_pipe_reg_arn #(.W(1), .USE_REG(CARRYINREG != 0)) u_cinreg (
    .clk(clk), .rst_n(rst_n), .ce(cecarryin), .d(carryin), .q(cin_q)
  );

  assign x_sel = x_sel_e'(opm_q[OPM_X_LSB +: 2]);
  assign z_sel = z_sel_e'(opm_q[OPM_Z_LSB +: 2]);
  assign sub   = opm_q[OPM_SUB_BIT];

  // opmode[6:4] carry no function in this stage
  logic unused_opm;
  assign unused_opm = &{1'b0, opm_q[6:4]};

  // Feedback comes only from a real P register; without one it reads as zero
  // so the adder never loops back on itself combinationally.
  generate
    if (PREG != 0) begin : g_fb
      assign p_fb = p_q;
    end else begin : g_no_fb
      assign p_fb = '0;
    end
  endgenerate

  always_comb begin
    x_op = '0;
    unique case (x_sel)
      X_ZERO: x_op = '0;
      X_M:    x_op = {{(DAT_W-M_W){1'b0}}, m_q};
      X_P:    x_op = p_fb;
      X_DAB:  x_op = dab;
    endcase
  end

  always_comb begin
    z_op = '0;
    unique case (z_sel)
      Z_ZERO: z_op = '0;
      Z_PCIN: z_op = pcin;
      Z_P:    z_op = p_fb;
      Z_C:    z_op = c;
    endcase
  end

  // 49-bit arithmetic: bit 48 is the carry (add) or borrow (subtract)
  always_comb begin
    if (sub)
      res = {1'b0, z_op} - ({1'b0, x_op} + {{DAT_W{1'b0}}, cin_q});
    else
      res = {1'b0, z_op} + {1'b0, x_op} + {{DAT_W{1'b0}}, cin_q};
  end

  dsp_pipe_reg_arn #(.W(DAT_W), .USE_REG(PREG != 0)) u_preg (
    .clk(clk), .rst_n(rst_n), .ce(cep), .d(res[DAT_W-1:0]), .q(p_q)
  );

  dsp_pipe_reg_arn #(.W(1), .USE_REG(CARRYOUTREG != 0)) u_coutreg (
    .clk(clk), .rst_n(rst_n), .ce(cep), .d(res[DAT_W]), .q(cout_q)
  );

  assign p         = p_q;
  assign pcout     = p_q;
  assign m_out     = m_q;
  assign carryout  = cout_q;
  assign carryoutf = cout_q;

endmodule

// File: tb/tb_dsp_post_stage.sv
module tb_dsp_post_stage;

  logic        clk;
  logic        rst_n;
  logic        cem, cep, ceopmode, cecarryin;
  logic [35:0] m;
  logic [47:0] dab, c, pcin;
  logic        carryin;
  logic [7:0]  opmode;

  logic [47:0] p1, pcout1;
  logic [35:0] m_out1;
  logic        co1, cof1;

  logic [47:0] p0, pcout0;
  logic [35:0] m_out0;
  logic        co0, cof0;

  int checks = 0;
  int errors = 0;

  dsp_post_stage u_dut_reg (
    .clk(clk), .rst_n(rst_n), .cem(cem), .cep(cep), .ceopmode(ceopmode),
    .cecarryin(cecarryin), .m(m), .dab(dab), .c(c), .pcin(pcin),
    .carryin(carryin), .opmode(opmode), .p(p1), .pcout(pcout1),
    .m_out(m_out1), .carryout(co1), .carryoutf(cof1)
  );

  dsp_post_stage #(.MREG(0), .PREG(0), .OPMODEREG(0), .CARRYINREG(0), .CARRYOUTREG(0))
  u_dut_comb (
    .clk(clk), .rst_n(rst_n), .cem(cem), .cep(cep), .ceopmode(ceopmode),
    .cecarryin(cecarryin), .m(m), .dab(dab), .c(c), .pcin(pcin),
    .carryin(carryin), .opmode(opmode), .p(p0), .pcout(pcout0),
    .m_out(m_out0), .carryout(co0), .carryoutf(cof0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cem = 1'b1; cep = 1'b1; ceopmode = 1'b1; cecarryin = 1'b1;
    m = 36'd9; dab = 48'd4; c = 48'd6; pcin = 48'd1; carryin = 1'b1;
    opmode = 8'h0F;
    step(); step();
    checks++;
    if (p1 !== 48'd0) begin errors++; $display("FAIL reset_p got %h want %h", p1, 48'd0); end
    checks++;
    if (m_out1 !== 36'd0) begin errors++; $display("FAIL reset_m_out got %h want %h", m_out1, 36'd0); end
    checks++;
    if (co1 !== 1'b0) begin errors++; $display("FAIL reset_carryout got %b want 0", co1); end
    opmode = 8'h00; carryin = 1'b0;
    rst_n = 1'b1;
    step(); step();
  endtask

  task automatic test_add_latency();
    opmode = 8'h0F; dab = 48'd5; c = 48'd7; carryin = 1'b1;
    step();
    checks++;
    if (p1 !== 48'd0) begin errors++; $display("FAIL add_lat1 got %h want %h", p1, 48'd0); end
    step();
    checks++;
    if (p1 !== 48'h00000000000D) begin errors++; $display("FAIL add_p got %h want %h", p1, 48'hD); end
    checks++;
    if (pcout1 !== 48'h00000000000D) begin errors++; $display("FAIL add_pcout got %h want %h", pcout1, 48'hD); end
    checks++;
    if (cof1 !== 1'b0) begin errors++; $display("FAIL add_carryoutf got %b want 0", cof1); end
  endtask

  task automatic test_subtract();
    opmode = 8'h8F; c = 48'd10; dab = 48'd3; carryin = 1'b0;
    step(); step();
    checks++;
    if (p1 !== 48'd7) begin errors++; $display("FAIL sub_p got %h want %h", p1, 48'd7); end
    checks++;
    if (co1 !== 1'b0) begin errors++; $display("FAIL sub_carryout got %b want 0", co1); end
    // dab/c to p is one cycle with opmode already staged
    c = 48'd0; dab = 48'd1;
    step();
    checks++;
    if (p1 !== 48'hFFFFFFFFFFFF) begin errors++; $display("FAIL sub_neg_p got %h want %h", p1, 48'hFFFFFFFFFFFF); end
    checks++;
    if (co1 !== 1'b1) begin errors++; $display("FAIL sub_neg_carryout got %b want 1", co1); end
    checks++;
    if (cof1 !== 1'b1) begin errors++; $display("FAIL sub_neg_carryoutf got %b want 1", cof1); end
  endtask

  task automatic test_wrap();
    opmode = 8'h0F; c = 48'hFFFFFFFFFFFF; dab = 48'd1; carryin = 1'b0;
    step(); step();
    checks++;
    if (p1 !== 48'd0) begin errors++; $display("FAIL wrap_p got %h want %h", p1, 48'd0); end
    checks++;
    if (co1 !== 1'b1) begin errors++; $display("FAIL wrap_carryout got %b want 1", co1); end
  endtask

  task automatic test_pcin();
    opmode = 8'h04; pcin = 48'h123456789ABC; carryin = 1'b1;
    step(); step();
    checks++;
    if (p1 !== 48'h123456789ABD) begin errors++; $display("FAIL pcin_p got %h want %h", p1, 48'h123456789ABD); end
    carryin = 1'b0;
  endtask

  task automatic test_accumulate();
    logic [47:0] exp_seq [4];
    exp_seq[0] = 48'd3; exp_seq[1] = 48'd6; exp_seq[2] = 48'd9; exp_seq[3] = 48'd12;
    rst_n = 1'b0;
    #2;
    opmode = 8'h09; m = 36'd3; carryin = 1'b0; cep = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (m_out1 !== 36'd3) begin errors++; $display("FAIL acc_m_out got %h want %h", m_out1, 36'd3); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (p1 !== exp_seq[i]) begin errors++; $display("FAIL acc_p%0d got %h want %h", i, p1, exp_seq[i]); end
    end
    cep = 1'b0;
    step();
    checks++;
    if (p1 !== 48'd12) begin errors++; $display("FAIL acc_hold_p got %h want %h", p1, 48'd12); end
    checks++;
    if (co1 !== 1'b0) begin errors++; $display("FAIL acc_hold_carryout got %b want 0", co1); end
    cep = 1'b1;
  endtask

  task automatic test_reset_mid_acc();
    rst_n = 1'b0;
    #2;
    opmode = 8'h09; m = 36'd3; cep = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(); step(); step(); step();
    checks++;
    if (p1 !== 48'd9) begin errors++; $display("FAIL mid_pre_p got %h want %h", p1, 48'd9); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (p1 !== 48'd0) begin errors++; $display("FAIL mid_rst_p got %h want %h", p1, 48'd0); end
    checks++;
    if (m_out1 !== 36'd0) begin errors++; $display("FAIL mid_rst_m_out got %h want %h", m_out1, 36'd0); end
    checks++;
    if (co1 !== 1'b0) begin errors++; $display("FAIL mid_rst_carryout got %b want 0", co1); end
    #1;
    rst_n = 1'b1;
    step(); step();
    checks++;
    if (p1 !== 48'd3) begin errors++; $display("FAIL mid_restart_p got %h want %h", p1, 48'd3); end
  endtask

  task automatic test_bypass();
    opmode = 8'h05; m = 36'd2; pcin = 48'd5; carryin = 1'b0;
    #1;
    checks++;
    if (p0 !== 48'd7) begin errors++; $display("FAIL byp_p got %h want %h", p0, 48'd7); end
    checks++;
    if (m_out0 !== 36'd2) begin errors++; $display("FAIL byp_m_out got %h want %h", m_out0, 36'd2); end
    opmode = 8'h06;
    #1;
    checks++;
    if (p0 !== 48'd5) begin errors++; $display("FAIL byp_fb_zero_p got %h want %h", p0, 48'd5); end
    opmode = 8'h87; dab = 48'd6; pcin = 48'd0;
    #1;
    checks++;
    if (co0 !== 1'b1) begin errors++; $display("FAIL byp_carryout got %b want 1", co0); end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_subtract();
    test_wrap();
    test_pcin();
    test_accumulate();
    test_reset_mid_acc();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
